// File: rtl/ff_bank_multi.sv
// ff_bank_multi: bank of WIDTH independent flip-flop channels that share one
// run-time selectable behaviour (SR, JK, D or T). Also provides registered
// per-channel SR-illegal flags and a saturating count of illegal cycles.
module ff_bank_multi #(
  parameter int               WIDTH   = 8,
  parameter int               CNT_W   = 8,
  parameter logic [WIDTH-1:0] RESET_Q = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             mode_ld,
  input  logic [1:0]       mode_in,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             clr_cnt,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic [1:0]       mode,
  output logic [WIDTH-1:0] illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  typedef enum logic [1:0] {
    MODE_SR = 2'b00,
    MODE_JK = 2'b01,
    MODE_D  = 2'b10,
    MODE_T  = 2'b11
  } mode_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  mode_e            r_mode;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_illegal;
  logic [CNT_W-1:0] r_cnt;

  logic [WIDTH-1:0] w_q_next;
  logic [WIDTH-1:0] w_illegal_next;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_sr_active;

  // SR mode is only "active" for illegal detection while channels are enabled;
  // the mode tested here is the pre-edge register, so a simultaneous mode_ld
  // does not influence this edge.
  assign w_sr_active    = en && (r_mode == MODE_SR);
  assign w_illegal_next = {WIDTH{w_sr_active}} & a & b;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi = gi + 1) begin : g_chan
      logic w_nxt;

      // Per-channel next state under the currently active mode; hold when disabled.
      always_comb begin
        w_nxt = r_q[gi];
        if (en) begin
          case (r_mode)
            MODE_SR: begin
              // Both set and reset asserted is illegal and simply holds.
              if (a[gi] && !b[gi])      w_nxt = 1'b1;
              else if (!a[gi] && b[gi]) w_nxt = 1'b0;
            end
            MODE_JK: begin
              if (a[gi] && !b[gi])      w_nxt = 1'b1;
              else if (!a[gi] && b[gi]) w_nxt = 1'b0;
              else if (a[gi] && b[gi])  w_nxt = ~r_q[gi];
            end
            MODE_D:  w_nxt = a[gi];
            MODE_T:  w_nxt = r_q[gi] ^ a[gi];
            default: w_nxt = r_q[gi];
          endcase
        end
      end

      assign w_q_next[gi] = w_nxt;
    end
  endgenerate

  // Counter next value: clear wins, otherwise one step per illegal cycle, saturating.
  always_comb begin
    w_cnt_next = r_cnt;
    if (clr_cnt) begin
      w_cnt_next = '0;
    end else if ((|w_illegal_next) && (r_cnt != CNT_MAX)) begin
      w_cnt_next = r_cnt + 1'b1;
    end
  end

  // Channel state, mode register and illegal flags; async reset overrides everything.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_q       <= RESET_Q;
      r_mode    <= MODE_SR;
      r_illegal <= '0;
    end else begin
      r_q       <= w_q_next;
      r_illegal <= w_illegal_next;
      if (mode_ld) begin
        r_mode <= mode_e'(mode_in);
      end
    end
  end

  // Illegal-cycle counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_next;
    end
  end

  // qbar is derived from q directly so it tracks q through reset too.
  assign q           = r_q;
  assign qbar        = ~r_q;
  assign mode        = r_mode;
  assign illegal     = r_illegal;
  assign illegal_cnt = r_cnt;

endmodule

// File: doc/ff_bank_multi.md
FF_BANK_MULTI -- requirements
Module: ff_bank_multi

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the number of independent flip-flop channels.
REQ-002 The block SHALL have parameter CNT_W, default 8, giving the width of the illegal-event counter.
REQ-003 The block SHALL have parameter RESET_Q, default all-zero (WIDTH bits), giving the reset value of q.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port en, input, 1 bit: channel update enable.
REQ-007 The block SHALL have port mode_ld, input, 1 bit: load strobe for mode_in.
REQ-008 The block SHALL have port mode_in, input, 2 bits: requested mode (00 SR, 01 JK, 10 D, 11 T).
REQ-009 The block SHALL have port a, input, WIDTH bits: per-channel S/J/D/T input.
REQ-010 The block SHALL have port b, input, WIDTH bits: per-channel R/K input, ignored in D and T modes.
REQ-011 The block SHALL have port clr_cnt, input, 1 bit: synchronous clear of illegal_cnt.
REQ-012 The block SHALL have port q, output, WIDTH bits: channel states.
REQ-013 The block SHALL have port qbar, output, WIDTH bits: bitwise complement of q.
REQ-014 The block SHALL have port mode, output, 2 bits: currently active mode register.
REQ-015 The block SHALL have port illegal, output, WIDTH bits: registered per-channel SR-illegal flags.
REQ-016 The block SHALL have port illegal_cnt, output, CNT_W bits: saturating count of illegal cycles.

Function
REQ-017 On each rising clk edge with en=1, each channel i SHALL update per the active mode:
- SR: a=1,b=0 -> 1; a=0,b=1 -> 0; a=0,b=0 -> hold; a=1,b=1 -> hold (illegal).
- JK: 10 -> 1; 01 -> 0; 00 -> hold; 11 -> toggle.
- D: q[i] <= a[i].
- T: a[i]=1 -> toggle; a[i]=0 -> hold.
REQ-018 With en=0, q SHALL hold in every mode.
REQ-019 qbar SHALL equal ~q at all times, including during reset, with no extra register.
REQ-020 mode_ld=1 SHALL load mode_in into mode at the edge; the channel update at that same edge SHALL use the old mode; the new mode SHALL apply from the next edge.
REQ-021 illegal[i] SHALL be registered each edge as en & (mode==SR) & a[i] & b[i], using the pre-edge mode, and SHALL clear the cycle after the condition ends.
REQ-022 illegal_cnt SHALL increment by exactly 1 on each edge where any channel meets the REQ-021 condition, regardless of how many channels meet it.
REQ-023 illegal_cnt SHALL saturate at 2^CNT_W-1 and not wrap.
REQ-024 clr_cnt=1 SHALL force illegal_cnt to 0 at the edge, taking priority over a simultaneous increment.
REQ-025 clr_cnt SHALL NOT affect q, mode, or illegal.
REQ-026 Output latency SHALL be one clock from inputs to q and illegal; there SHALL be no combinational path from a or b to any output.

Reset
REQ-027 While reset=0, independent of clk, outputs SHALL be: q=RESET_Q, qbar=~RESET_Q, mode=00 (SR), illegal=0, illegal_cnt=0.
REQ-028 Reset asserted mid-operation SHALL override all inputs immediately, including pending mode_ld and clr_cnt.
REQ-029 The first rising edge after reset deasserts SHALL perform a normal update per REQ-017.

Verification
REQ-030 Reset/SR (WIDTH=4, RESET_Q=0): reset=0 -> q=0000, qbar=1111, mode=00. Then en=1, a=0101, b=0010 for one edge -> q=0101. Then a=0000, b=0000 -> q holds 0101.
REQ-031 SR illegal: q=0101, a=0011, b=0011 for 3 edges -> q=0101 held, illegal=0011, illegal_cnt=3. Then a=b=0 -> illegal=0000 after one edge, illegal_cnt stays 3.
REQ-032 Mode switch: mode_ld=1, mode_in=11 with a=1111 at the same edge -> update uses SR with b=0, so q=1111, mode=11. Next edge with a=1010 -> q=0101.
REQ-033 JK and D: mode=01, q=0000, a=b=1111 -> q=1111, then 0000 on alternate edges. mode=10, a=1001 -> q=1001. en=0 with a=0110 -> q=1001 held.
REQ-034 Counter: CNT_W=2, illegal held 5 edges -> illegal_cnt sequence 1,2,3,3,3. clr_cnt=1 with illegal still active -> illegal_cnt=0. Next edge -> illegal_cnt=1.
REQ-035 Async reset mid-run: q=1010, mode=11, illegal_cnt=2; assert reset between edges -> all outputs reach reset values before the next clk edge. Check that qbar=~q throughout.
